// File: rtl/debounce_pkg.sv
// Shared constants, level encoding and width helper for the multi-channel debouncer.
package debounce_pkg;

    localparam int STABLE_DEF = 16;
    localparam int LONG_DEF   = 1000;
    localparam int REPEAT_DEF = 250;

    typedef enum logic {
        LVL_LO = 1'b0,
        LVL_HI = 1'b1
    } lvl_e;

    // Counter width for a modulus of v; never collapses to a zero-width vector.
    function automatic int cw(input int v);
        int w;
        w = $clog2(v);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debounce channel: 2-FF synchroniser, stability filter, edge strobes and
// hold/auto-repeat timing for a single raw input.
module debounce_chan
    import debounce_pkg::*;
#(
    parameter int STABLE    = STABLE_DEF,
    parameter int LONG      = LONG_DEF,
    parameter int REPEAT    = REPEAT_DEF,
    parameter int REPEAT_EN = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic i,
    output logic st_o,
    output logic up_o,
    output logic dn_o,
    output logic long_o,
    output logic rep_o
);

    localparam int SW = cw(STABLE);
    localparam int HW = cw(LONG + REPEAT);
    localparam int RW = cw(REPEAT);

    localparam logic [SW-1:0] STB_MAX  = SW'(STABLE - 1);
    localparam logic [HW-1:0] HOLD_SAT = HW'(LONG);
    localparam logic [HW-1:0] LONG_M1  = HW'(LONG - 1);
    localparam logic [RW-1:0] REP_MAX  = RW'(REPEAT - 1);

    logic          s1_q, s2_q;
    lvl_e          state_q, state_d;
    logic [SW-1:0] scnt_q, scnt_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [RW-1:0] rcnt_q, rcnt_d;
    logic          up_q, up_d, dn_q, dn_d;
    logic          long_q, long_d, rep_q, rep_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            state_q <= LVL_LO;
            scnt_q  <= '0;
            hold_q  <= '0;
            rcnt_q  <= '0;
            up_q    <= 1'b0;
            dn_q    <= 1'b0;
            long_q  <= 1'b0;
            rep_q   <= 1'b0;
        end else begin
            s1_q    <= i;
            s2_q    <= s1_q;
            state_q <= state_d;
            scnt_q  <= scnt_d;
            hold_q  <= hold_d;
            rcnt_q  <= rcnt_d;
            up_q    <= up_d;
            dn_q    <= dn_d;
            long_q  <= long_d;
            rep_q   <= rep_d;
        end
    end

    // Any cycle where s2 agrees with the current level restarts the count.
    always_comb begin
        state_d = state_q;
        scnt_d  = '0;
        up_d    = 1'b0;
        dn_d    = 1'b0;
        if (s2_q != (state_q == LVL_HI)) begin
            if (scnt_q == STB_MAX) begin
                state_d = (state_q == LVL_HI) ? LVL_LO : LVL_HI;
                up_d    = (state_q == LVL_LO);
                dn_d    = (state_q == LVL_HI);
            end else begin
                scnt_d = scnt_q + 1'b1;
            end
        end
    end

    // Hold timing only runs while the level stays high across the edge, so a
    // release edge can never carry a long or repeat strobe.
    always_comb begin
        hold_d = '0;
        rcnt_d = '0;
        long_d = 1'b0;
        rep_d  = 1'b0;
        if (state_q == LVL_HI && state_d == LVL_HI) begin
            hold_d = (hold_q == HOLD_SAT) ? hold_q : hold_q + 1'b1;
            long_d = (hold_q == LONG_M1);
            if (hold_q == HOLD_SAT) begin
                if (rcnt_q == REP_MAX) begin
                    rep_d = (REPEAT_EN != 0);
                end else begin
                    rcnt_d = rcnt_q + 1'b1;
                end
            end
        end
    end

    assign st_o   = (state_q == LVL_HI);
    assign up_o   = up_q;
    assign dn_o   = dn_q;
    assign long_o = long_q;
    assign rep_o  = rep_q;

endmodule

// File: rtl/debounce_multi.sv
// N independent debounce channels behind board button/switch pins.
module debounce_multi
    import debounce_pkg::*;
#(
    parameter int N         = 4,
    parameter int STABLE    = STABLE_DEF,
    parameter int LONG      = LONG_DEF,
    parameter int REPEAT    = REPEAT_DEF,
    parameter int REPEAT_EN = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] i,
    output logic [N-1:0] st_o,
    output logic [N-1:0] up_o,
    output logic [N-1:0] dn_o,
    output logic [N-1:0] long_o,
    output logic [N-1:0] rep_o
);

    for (genvar g = 0; g < N; g++) begin : g_chan
        debounce_chan #(
            .STABLE   (STABLE),
            .LONG     (LONG),
            .REPEAT   (REPEAT),
            .REPEAT_EN(REPEAT_EN)
        ) u_chan (
            .clk   (clk),
            .rst   (rst),
            .i     (i[g]),
            .st_o  (st_o[g]),
            .up_o  (up_o[g]),
            .dn_o  (dn_o[g]),
            .long_o(long_o[g]),
            .rep_o (rep_o[g])
        );
    end

endmodule

// File: tb/tb_debounce_multi.sv
// Random press/bounce stimulus on two channels, checked cycle by cycle against
// a history-window reference model; a second build has auto-repeat disabled.
module tb_debounce_multi;
    import debounce_pkg::*;

    localparam int NCH    = 2;
    localparam int STB    = 4;
    localparam int LNG    = 20;
    localparam int RPT    = 8;
    localparam int NCYC   = 3000;
    localparam int RST_AT = 1525;

    logic           clk = 1'b0;
    logic           rst;
    logic [NCH-1:0] in_r;
    logic [NCH-1:0] st_a, up_a, dn_a, long_a, rep_a;
    logic [NCH-1:0] st_b, up_b, dn_b, long_b, rep_b;

    int errors = 0;
    int checks = 0;

    always #10 clk = ~clk;

    debounce_multi #(.N(NCH), .STABLE(STB), .LONG(LNG), .REPEAT(RPT), .REPEAT_EN(1)) dut (
        .clk(clk), .rst(rst), .i(in_r),
        .st_o(st_a), .up_o(up_a), .dn_o(dn_a), .long_o(long_a), .rep_o(rep_a)
    );

    debounce_multi #(.N(NCH), .STABLE(STB), .LONG(LNG), .REPEAT(RPT), .REPEAT_EN(0)) dut_nr (
        .clk(clk), .rst(rst), .i(in_r),
        .st_o(st_b), .up_o(up_b), .dn_o(dn_b), .long_o(long_b), .rep_o(rep_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got=%0h expected=%0h", tag, $time, got, exp);
        end
    endtask

    // Reference: raw samples recorded per edge; the filter sees each sample two
    // edges later, and a level flips once STABLE consecutive seen samples all
    // disagree with it. Hold strobes follow from the time since the last rise.
    bit             smp [NCH][NCYC+4];
    bit             st_m [NCH];
    int             rise_t [NCH];
    logic [NCH-1:0] e_st, e_up, e_dn, e_long, e_rep;
    int             seg_left [NCH];
    bit             cur [NCH];
    int             n_long, n_rep;

    function automatic bit seen(input int c, input int t);
        return (t - 2 >= 0) ? smp[c][t-2] : 1'b0;
    endfunction

    task automatic model(input int t);
        bit flip, nv;
        int d;
        for (int c = 0; c < NCH; c++) begin
            if (rst) begin
                smp[c][t] = 1'b0;
                st_m[c]   = 1'b0;
                rise_t[c] = -100000;
                e_st[c] = 0; e_up[c] = 0; e_dn[c] = 0; e_long[c] = 0; e_rep[c] = 0;
            end else begin
                smp[c][t] = in_r[c];
                flip = 1'b1;
                for (int j = 0; j < STB; j++)
                    if (seen(c, t - j) == st_m[c]) flip = 1'b0;
                nv = flip ? ~st_m[c] : st_m[c];
                e_up[c] = flip && nv;
                e_dn[c] = flip && !nv;
                if (flip && nv) rise_t[c] = t;
                d = t - rise_t[c];
                e_long[c] = nv && !flip && (d == LNG);
                e_rep[c]  = nv && !flip && (d > LNG) && ((d - LNG) % RPT == 0);
                st_m[c] = nv;
                e_st[c] = nv;
            end
        end
    endtask

    task automatic drive();
        int r;
        for (int c = 0; c < NCH; c++) begin
            if (seg_left[c] == 0) begin
                r = $urandom_range(0, 9);
                cur[c] = ~cur[c];
                if (r < 4)      seg_left[c] = $urandom_range(1, 3);
                else if (r < 7) seg_left[c] = $urandom_range(4, 15);
                else            seg_left[c] = $urandom_range(20, 70);
            end
            seg_left[c]--;
            in_r[c] = cur[c];
        end
    endtask

    task automatic check_all();
        chk("st",     32'(st_a),   32'(e_st));
        chk("up",     32'(up_a),   32'(e_up));
        chk("dn",     32'(dn_a),   32'(e_dn));
        chk("long",   32'(long_a), 32'(e_long));
        chk("rep",    32'(rep_a),  32'(e_rep));
        chk("nr_st",  32'(st_b),   32'(e_st));
        chk("nr_up",  32'(up_b),   32'(e_up));
        chk("nr_dn",  32'(dn_b),   32'(e_dn));
        chk("nr_long",32'(long_b), 32'(e_long));
        chk("nr_rep", 32'(rep_b),  32'd0);
        n_long += $countones(long_a);
        n_rep  += $countones(rep_a);
    endtask

    initial begin
        rst  = 1'b1;
        in_r = '0;
        n_long = 0;
        n_rep  = 0;
        for (int c = 0; c < NCH; c++) begin
            seg_left[c] = 0;
            cur[c]      = 1'b0;
            st_m[c]     = 1'b0;
            rise_t[c]   = -100000;
        end
        for (int t = 0; t < NCYC; t++) begin
            @(posedge clk);
            model(t);
            #1;
            check_all();
            if (t == 2) rst = 1'b0;
            if (t == RST_AT - 25) begin
                for (int c = 0; c < NCH; c++) begin
                    cur[c] = 1'b1;
                    seg_left[c] = 80;
                end
            end
            if (t == RST_AT) begin
                #3;
                rst = 1'b1;
                #1;
                e_st = '0; e_up = '0; e_dn = '0; e_long = '0; e_rep = '0;
                for (int c = 0; c < NCH; c++) st_m[c] = 1'b0;
                check_all();
            end
            if (t == RST_AT + 3) rst = 1'b0;
            drive();
        end
        chk("long_seen", 32'(n_long > 0), 32'd1);
        chk("rep_seen",  32'(n_rep > 0),  32'd1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
